// File: rtl/rx_udp_buffer.sv
// ---------------------------------------------------------------------------
// rx_udp_buffer
//   Payload buffer behind the UDP receive stage. The incoming byte stream is
//   written speculatively into a circular byte RAM. A datagram becomes
//   visible to the host only when rx_udp_irq commits it. An aborted datagram
//   is rolled back. A datagram that runs out of space is also rolled back and
//   counted as dropped. The host reads the head datagram's length, pulls its
//   bytes with rd_en, and releases it with frm_pop.
//
//   Optional feature macro: RX_BUF_AUTO_POP_EN
//     When this macro is defined, the rd_en that returns the last byte of the
//     head datagram also releases that datagram. For a zero-length datagram,
//     any rd_en releases it.
//
// Ports
//   RX_CLK         sole clock
//   rst            synchronous active-high reset
//   rx_udp_data_v  payload byte valid
//   rx_udp_data    payload byte
//   rx_udp_irq     one-cycle pulse: current datagram complete and good
//   rx_abort       one-cycle pulse: discard the in-progress datagram
//   frm_avail      at least one committed datagram present
//   frm_len        length of head datagram (0 when frm_avail=0)
//   frm_cnt        number of committed datagrams held
//   rd_en          request next byte of head datagram
//   rd_data        read byte (registered)
//   rd_valid       rd_data valid this cycle
//   frm_pop        release head datagram
//   drop_cnt       datagrams dropped for lack of space (saturating)
// ---------------------------------------------------------------------------
module rx_udp_buffer #(
    parameter int OCT            = 8,
    parameter int ADDR_W         = 11,
    parameter int LEN_DEPTH_LOG2 = 2,
    parameter int LEN_W          = 16
) (
    input  logic                      RX_CLK,
    input  logic                      rst,
    input  logic                      rx_udp_data_v,
    input  logic [OCT-1:0]            rx_udp_data,
    input  logic                      rx_udp_irq,
    input  logic                      rx_abort,
    output logic                      frm_avail,
    output logic [LEN_W-1:0]          frm_len,
    output logic [LEN_DEPTH_LOG2:0]   frm_cnt,
    input  logic                      rd_en,
    output logic [OCT-1:0]            rd_data,
    output logic                      rd_valid,
    input  logic                      frm_pop,
    output logic [15:0]               drop_cnt
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = LEN_DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{LEN_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {LEN_DEPTH_LOG2{1'b0}}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_DEPTH_LOG2-1:0] LIDX_ONE = {{(LEN_DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;

    logic [OCT-1:0]            data_mem [0:(2**ADDR_W)-1];
    logic [LEN_W-1:0]          len_mem  [0:(2**LEN_DEPTH_LOG2)-1];

    state_t                    state_r, state_nxt_s;
    logic [PTR_W-1:0]          wr_ptr_r, cmt_ptr_r, hd_ptr_r;
    logic [LEN_W-1:0]          len_r, len_nxt_s, rd_off_r;
    logic [LEN_DEPTH_LOG2-1:0] lwr_r, lrd_r, lrd_nxt_s;
    logic [CNT_W-1:0]          frm_cnt_r, cnt_nxt_s;
    logic                      frm_avail_r, rd_valid_r;
    logic [LEN_W-1:0]          frm_len_r, frm_len_nxt_s;
    logic [OCT-1:0]            rd_data_r;
    logic [15:0]               drop_cnt_r;

    logic                      space_s, lfull_s;
    logic                      wr_byte_s, push_s, rollback_s, cmt_adv_s, drop_inc_s;
    logic [LEN_W-1:0]          push_len_s, inc_s;
    logic                      rd_go_s, pop_go_s, auto_pop_s, head_is_new_s;
    logic [ADDR_W-1:0]         rd_addr_s;

    // Space is released only when the head datagram is popped, so the free
    // boundary is the head start pointer, not the read position.
    assign space_s   = ((wr_ptr_r - hd_ptr_r) != PTR_FULL);
    assign lfull_s   = (frm_cnt_r == CNT_FULL);
    assign inc_s     = rx_udp_data_v ? LEN_ONE : {LEN_W{1'b0}};
    assign rd_addr_s = hd_ptr_r[ADDR_W-1:0] + ADDR_W'(rd_off_r);

    assign rd_go_s  = rd_en && !frm_pop && frm_avail_r && (rd_off_r < frm_len_r);
`ifdef RX_BUF_AUTO_POP_EN
    assign auto_pop_s = rd_en && !frm_pop && frm_avail_r &&
                        ((frm_len_r == {LEN_W{1'b0}}) ||
                         (rd_go_s && (rd_off_r == (frm_len_r - LEN_ONE))));
`else
    assign auto_pop_s = 1'b0;
`endif
    assign pop_go_s = (frm_pop && frm_avail_r) || auto_pop_s;

    // Write-side next-state logic: decides byte writes, commits, rollbacks and drops
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        wr_byte_s   = 1'b0;
        push_s      = 1'b0;
        push_len_s  = {LEN_W{1'b0}};
        rollback_s  = 1'b0;
        cmt_adv_s   = 1'b0;
        drop_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (rx_udp_data_v) begin
                    if (space_s && !lfull_s) begin
                        wr_byte_s = 1'b1;
                        if (rx_udp_irq) begin
                            // single-byte datagram completes in the same cycle
                            push_s     = 1'b1;
                            push_len_s = LEN_ONE;
                            cmt_adv_s  = 1'b1;
                        end else begin
                            len_nxt_s   = LEN_ONE;
                            state_nxt_s = ST_RECV;
                        end
                    end else begin
                        rollback_s  = 1'b1;
                        drop_inc_s  = 1'b1;
                        state_nxt_s = rx_udp_irq ? ST_IDLE : ST_DROP;
                    end
                end else if (rx_udp_irq) begin
                    // zero-length datagram
                    if (!lfull_s) begin
                        push_s = 1'b1;
                    end else begin
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rx_abort) begin
                    rollback_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (rx_udp_data_v && !(space_s && (len_r < LEN_MAX))) begin
                    rollback_s  = 1'b1;
                    drop_inc_s  = 1'b1;
                    state_nxt_s = rx_udp_irq ? ST_IDLE : ST_DROP;
                end else begin
                    wr_byte_s = rx_udp_data_v;
                    if (rx_udp_irq) begin
                        push_s      = 1'b1;
                        push_len_s  = len_r + inc_s;
                        cmt_adv_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        len_nxt_s = len_r + inc_s;
                    end
                end
            end
            ST_DROP: begin
                if (rx_abort || rx_udp_irq) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Length FIFO next-state: count, read index and the head length seen next cycle
    always_comb begin
        lrd_nxt_s     = pop_go_s ? (lrd_r + LIDX_ONE) : lrd_r;
        cnt_nxt_s     = frm_cnt_r;
        head_is_new_s = push_s && ((frm_cnt_r == {CNT_W{1'b0}}) ||
                                   (pop_go_s && (frm_cnt_r == CNT_ONE)));
        case ({push_s, pop_go_s})
            2'b10:   cnt_nxt_s = frm_cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = frm_cnt_r - CNT_ONE;
            default: cnt_nxt_s = frm_cnt_r;
        endcase
        if (cnt_nxt_s == {CNT_W{1'b0}}) begin
            frm_len_nxt_s = {LEN_W{1'b0}};
        end else if (head_is_new_s) begin
            frm_len_nxt_s = push_len_s;
        end else begin
            frm_len_nxt_s = len_mem[lrd_nxt_s];
        end
    end

    // Payload RAM write port
    always_ff @(posedge RX_CLK) begin
        if (wr_byte_s) begin
            data_mem[wr_ptr_r[ADDR_W-1:0]] <= rx_udp_data;
        end
    end

    // Length FIFO storage write port
    always_ff @(posedge RX_CLK) begin
        if (push_s) begin
            len_mem[lwr_r] <= push_len_s;
        end
    end

    // Write-side state, speculative/committed pointers and drop counter
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            len_r      <= {LEN_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            cmt_ptr_r  <= {PTR_W{1'b0}};
            drop_cnt_r <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            if (rollback_s) begin
                wr_ptr_r <= cmt_ptr_r;
            end else if (wr_byte_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (cmt_adv_s) begin
                cmt_ptr_r <= wr_byte_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            end
            if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    // Read side: head pointer, read offset and registered read data
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            hd_ptr_r   <= {PTR_W{1'b0}};
            rd_off_r   <= {LEN_W{1'b0}};
            rd_data_r  <= {OCT{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_go_s;
            if (rd_go_s) begin
                rd_data_r <= data_mem[rd_addr_s];
            end
            if (pop_go_s) begin
                // skip any unread bytes of the released datagram
                hd_ptr_r <= hd_ptr_r + PTR_W'(frm_len_r);
                rd_off_r <= {LEN_W{1'b0}};
            end else if (rd_go_s) begin
                rd_off_r <= rd_off_r + LEN_ONE;
            end
        end
    end

    // Length FIFO pointers and registered head-status outputs
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            lwr_r       <= {LEN_DEPTH_LOG2{1'b0}};
            lrd_r       <= {LEN_DEPTH_LOG2{1'b0}};
            frm_cnt_r   <= {CNT_W{1'b0}};
            frm_avail_r <= 1'b0;
            frm_len_r   <= {LEN_W{1'b0}};
        end else begin
            if (push_s) begin
                lwr_r <= lwr_r + LIDX_ONE;
            end
            lrd_r       <= lrd_nxt_s;
            frm_cnt_r   <= cnt_nxt_s;
            frm_avail_r <= (cnt_nxt_s != {CNT_W{1'b0}});
            frm_len_r   <= frm_len_nxt_s;
        end
    end

    assign frm_avail = frm_avail_r;
    assign frm_len   = frm_len_r;
    assign frm_cnt   = frm_cnt_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_rx_udp_buffer.sv
// ---------------------------------------------------------------------------
// tb_rx_udp_buffer
//   Self-checking bench for rx_udp_buffer, built with a 16-byte RAM and a
//   4-entry length FIFO. A reference model holds the committed datagrams as
//   byte/length queues and predicts every output each cycle. Directed
//   scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_rx_udp_buffer;

    localparam int OCT            = 8;
    localparam int ADDR_W         = 4;
    localparam int LEN_DEPTH_LOG2 = 2;
    localparam int LEN_W          = 16;
    localparam int DEPTH          = 16;
    localparam int NLEN           = 4;
`ifdef RX_BUF_AUTO_POP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                    RX_CLK = 1'b0;
    logic                    rst = 1'b1;
    logic                    rx_udp_data_v = 1'b0;
    logic [OCT-1:0]          rx_udp_data = 8'h00;
    logic                    rx_udp_irq = 1'b0;
    logic                    rx_abort = 1'b0;
    logic                    rd_en = 1'b0;
    logic                    frm_pop = 1'b0;
    logic                    frm_avail;
    logic [LEN_W-1:0]        frm_len;
    logic [LEN_DEPTH_LOG2:0] frm_cnt;
    logic [OCT-1:0]          rd_data;
    logic                    rd_valid;
    logic [15:0]             drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] cbytes[$];
    int         clens[$];
    logic [7:0] pbytes[$];
    bit         active, dropping;
    int         off, drops;
    logic [7:0] exp_rd_data;
    bit         exp_rd_valid;

    rx_udp_buffer #(
        .OCT(OCT), .ADDR_W(ADDR_W), .LEN_DEPTH_LOG2(LEN_DEPTH_LOG2), .LEN_W(LEN_W)
    ) dut (
        .RX_CLK(RX_CLK), .rst(rst),
        .rx_udp_data_v(rx_udp_data_v), .rx_udp_data(rx_udp_data),
        .rx_udp_irq(rx_udp_irq), .rx_abort(rx_abort),
        .frm_avail(frm_avail), .frm_len(frm_len), .frm_cnt(frm_cnt),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .frm_pop(frm_pop), .drop_cnt(drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit_model();
        clens.push_back(pbytes.size());
        foreach (pbytes[i]) cbytes.push_back(pbytes[i]);
        pbytes.delete();
        active = 1'b0;
    endtask

    task automatic model_update();
        bit avail, space, lfree, pop, rd;
        int hlen;
        if (rst) begin
            cbytes.delete(); clens.delete(); pbytes.delete();
            active = 0; dropping = 0; off = 0; drops = 0;
            exp_rd_data = 8'h00; exp_rd_valid = 0;
            return;
        end
        avail = (clens.size() != 0);
        hlen  = avail ? clens[0] : 0;
        space = (cbytes.size() + pbytes.size()) < DEPTH;
        lfree = clens.size() < NLEN;
        // host side
        pop = frm_pop && avail;
        rd  = !frm_pop && rd_en && avail && (off < hlen);
        exp_rd_valid = rd;
        if (rd) begin
            exp_rd_data = cbytes[off];
            off++;
        end
        if (AUTO && !frm_pop && rd_en && avail && (hlen == 0 || (rd && off == hlen))) pop = 1;
        if (pop) begin
            repeat (hlen) void'(cbytes.pop_front());
            void'(clens.pop_front());
            off = 0;
        end
        // receive side
        if (dropping) begin
            if (rx_abort || rx_udp_irq) dropping = 0;
        end else if (active) begin
            if (rx_abort) begin
                pbytes.delete();
                active = 0;
            end else begin
                if (rx_udp_data_v) begin
                    if (space && pbytes.size() < 65535) pbytes.push_back(rx_udp_data);
                    else begin
                        pbytes.delete(); drops++; active = 0; dropping = !rx_udp_irq;
                    end
                end
                if (active && rx_udp_irq) commit_model();
            end
        end else if (!rx_abort) begin
            if (rx_udp_data_v) begin
                if (space && lfree) begin
                    pbytes.push_back(rx_udp_data);
                    active = 1;
                    if (rx_udp_irq) commit_model();
                end else begin
                    drops++; dropping = !rx_udp_irq;
                end
            end else if (rx_udp_irq) begin
                if (lfree) clens.push_back(0);
                else drops++;
            end
        end
    endtask

    task automatic compare_all();
        chk("frm_avail", frm_avail, (clens.size() != 0));
        chk("frm_len", frm_len, (clens.size() != 0) ? clens[0] : 0);
        chk("frm_cnt", frm_cnt, clens.size());
        chk("drop_cnt", drop_cnt, (drops > 65535) ? 65535 : drops);
        chk("rd_valid", rd_valid, exp_rd_valid);
        chk("rd_data", rd_data, exp_rd_data);
    endtask

    task automatic tick();
        @(posedge RX_CLK);
        model_update();
        #1;
        compare_all();
        rx_udp_data_v = 1'b0; rx_udp_irq = 1'b0; rx_abort = 1'b0;
        rd_en = 1'b0; frm_pop = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_udp_data_v = 1'b1; rx_udp_data = b; tick();
    endtask
    task automatic irq_pulse();   rx_udp_irq = 1'b1; tick(); endtask
    task automatic abort_pulse(); rx_abort = 1'b1;   tick(); endtask
    task automatic rd_one();      rd_en = 1'b1;      tick(); endtask
    task automatic pop_now();     frm_pop = 1'b1;    tick(); endtask
    task automatic pop_manual();
        if (!AUTO) pop_now();
    endtask

    initial begin
        logic [7:0] t1 [4];
        logic [7:0] seq;
        t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;

        // reset
        rst = 1'b1; tick(); tick();
        chk("rst_avail", frm_avail, 32'd0);
        chk("rst_cnt", frm_cnt, 32'd0);
        chk("rst_drop", drop_cnt, 32'd0);
        rst = 1'b0; tick();

        // T1: four bytes, commit, read back, over-read
        for (int i = 0; i < 4; i++) put_byte(t1[i]);
        chk("t1_avail_pre", frm_avail, 32'd0);
        irq_pulse();
        chk("t1_avail", frm_avail, 32'd1);
        chk("t1_len", frm_len, 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd_one();
            chk("t1_rd_data", rd_data, t1[i]);
            chk("t1_rd_valid", rd_valid, 32'd1);
        end
        rd_one();
        chk("t1_overread", rd_valid, 32'd0);
        pop_manual();

        // T2: abort then a good datagram
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); abort_pulse();
        put_byte(8'hAA); put_byte(8'hBB); irq_pulse();
        chk("t2_cnt", frm_cnt, 32'd1);
        chk("t2_len", frm_len, 32'd2);
        chk("t2_drop", drop_cnt, 32'd0);
        rd_one(); chk("t2_rd0", rd_data, 32'hAA);
        rd_one(); chk("t2_rd1", rd_data, 32'hBB);
        pop_manual();

        // T3: oversize datagram dropped, exact-fit datagram accepted
        for (int i = 0; i < 20; i++) put_byte(8'(i));
        irq_pulse();
        chk("t3_drop", drop_cnt, 32'd1);
        chk("t3_avail", frm_avail, 32'd0);
        for (int i = 0; i < 16; i++) put_byte(8'(8'h40 + i));
        irq_pulse();
        chk("t3_len", frm_len, 32'd16);
        for (int i = 0; i < 16; i++) begin
            rd_one();
            chk("t3_rd", rd_data, 8'h40 + i);
        end
        pop_manual();

        // T4: length FIFO overflow
        for (int i = 0; i < 5; i++) begin
            put_byte(8'(8'hA0 + i)); irq_pulse();
        end
        chk("t4_cnt", frm_cnt, 32'd4);
        chk("t4_drop", drop_cnt, 32'd2);
        for (int i = 0; i < 4; i++) begin
            rd_one();
            chk("t4_rd", rd_data, 8'hA0 + i);
            pop_manual();
        end

        // T5: pop skips unread bytes
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); irq_pulse();
        put_byte(8'h04); put_byte(8'h05); irq_pulse();
        rd_one(); chk("t5_rd0", rd_data, 32'h01);
        pop_now();
        chk("t5_len", frm_len, 32'd2);
        rd_one(); chk("t5_rd1", rd_data, 32'h04);
        rd_one(); chk("t5_rd2", rd_data, 32'h05);
        pop_manual();

        // T6: six-byte datagrams across pointer wrap
        seq = 8'h00;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 6; i++) put_byte(8'(seq + i));
            irq_pulse();
            for (int i = 0; i < 6; i++) begin
                rd_one();
                chk("t6_rd", rd_data, 8'(seq + i));
            end
            chk("t6_cnt", frm_cnt, AUTO ? 32'd0 : 32'd1);
            pop_manual();
            seq = seq + 8'd6;
        end

        // same-cycle byte+irq, and zero-length datagram
        rx_udp_data_v = 1'b1; rx_udp_data = 8'h5A; rx_udp_irq = 1'b1; tick();
        chk("sc_len", frm_len, 32'd1);
        rd_one(); chk("sc_rd", rd_data, 32'h5A);
        pop_manual();
        irq_pulse();
        chk("zl_cnt", frm_cnt, 32'd1);
        chk("zl_len", frm_len, 32'd0);
        rd_one();
        pop_manual();

        // reset mid-datagram
        put_byte(8'h77); put_byte(8'h78);
        rst = 1'b1; tick(); rst = 1'b0;
        irq_pulse();
        chk("mr_cnt", frm_cnt, 32'd1);
        chk("mr_len", frm_len, 32'd0);
        pop_now();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rx_udp_data_v = ($urandom_range(0, 99) < 45);
            rx_udp_data   = 8'($urandom);
            rx_udp_irq    = ($urandom_range(0, 99) < 8);
            rx_abort      = ($urandom_range(0, 99) < 2);
            rd_en         = ($urandom_range(0, 99) < 40);
            frm_pop       = ($urandom_range(0, 99) < 6);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
